spi_reg_master: RTL and testbench
=================================

// Module: spi_reg_master
// PURPOSE
// - SPI initiator that writes and reads filter_top's 8-bit-addressed, 12-bit coefficient/config registers over SCK/CS/MOSI/MISO.
// - Accepts one register request at a time on a valid/ready port and serialises it into the team's 32-bit frame.
// - For reads it captures the slave's 12-bit reply from MISO; it replaces the bit-banged bench master and drives filter_top on hardware.
// PARAMETERS
// - CLK_DIV      4      Clk cycles per SCK half-period; legal range 1..255.
// - WR_PREAMBLE  8'hFB  Frame bits [31:24] for a register write.
// - RD_PREAMBLE  8'hFD  Frame bits [31:24] for a register read.
// - GAP_HALVES   2      Minimum CS-high time between frames, in SCK half-periods; legal range >= 1.
// PORTS
// - Clk        in   1   System clock; SCK is derived from it.
// - Rst_n      in   1   Asynchronous, active-low reset.
// - Req_valid  in   1   Request present.
// - Req_ready  out  1   Block is idle and accepts a request.
// - Req_rw     in   1   0 = write, 1 = read.
// - Req_addr   in   8   Register address.
// - Req_wdata  in   12  Write data. Ignored for reads.
// - Rsp_valid  out  1   One-Clk pulse when the frame completes (reads and writes).
// - Rsp_rdata  out  12  Read data. Valid with Rsp_valid; 0 for writes.
// - Busy       out  1   High from request acceptance until the gap ends.
// - SCK        out  1   SPI clock, mode 0, idles low.
// - CS         out  1   Active-low chip select.
// - MOSI       out  1   Serial data out, MSB first.
// - MISO       in   1   Serial data in; synchronous to SCK generated here.
// BEHAVIOUR
// - Reset values: CS=1, SCK=0, MOSI=0, Req_ready=1, Busy=0, Rsp_valid=0, Rsp_rdata=0, state=IDLE.
// - Asserting Rst_n low mid-frame forces CS high and SCK low immediately (asynchronously) and aborts the frame with no Rsp_valid.
// - Handshake: a request is taken on a Clk edge where Req_valid && Req_ready.
//   - All request fields are latched on that edge.
//   - Req_ready drops on the next cycle and stays low until the block returns to IDLE.
// - Frame: {preamble[7:0], addr[7:0], 4'b0000, data[11:0]}; data is 12'h000 for reads.
// - States and transitions:
//   - IDLE: on acceptance, load the shift register, CS=0, drive MOSI=frame[31] -> SETUP.
//   - SETUP: wait CLK_DIV cycles (MOSI setup before the first rising edge) -> SHIFT.
//   - SHIFT: each SCK rise samples MISO. Each SCK fall shifts the next MOSI bit out.
//     - Write: 32 rising edges.
//     - Read: 32 command edges plus 16 reply edges. During the reply phase MOSI=0.
//     - After the last rising edge, SCK returns low after CLK_DIV cycles -> HOLD.
//   - HOLD: CLK_DIV cycles with SCK low, then CS=1 and Rsp_valid pulses for one cycle -> GAP.
//   - GAP: GAP_HALVES*CLK_DIV cycles with CS high -> IDLE (Req_ready=1).
// - Read reply: the 16 reply bits are taken MSB first.
//   - The first 4 bits are ignored.
//   - The last 12 bits form Rsp_rdata, which is updated on the Rsp_valid cycle and held until the next response.
// - Latency from acceptance to Rsp_valid:
//   - Write: 2*CLK_DIV*32 + 2*CLK_DIV + 1 Clk cycles.
//   - Read: the same with 48 in place of 32.
// - Back-to-back requests: a request held valid during Busy waits. The next CS fall is never earlier than GAP_HALVES*CLK_DIV cycles after CS rise.
// - Bit counter is 6 bits and saturates at the frame length; no wrap into a new frame.
// - CLK_DIV=1: SCK toggles every Clk cycle, giving SCK = Clk/2; all rules above still hold.
// STRUCTURE
// - spi_reg_pkg holds:
//   - WR/RD preamble defaults and frame field widths/offsets (FRAME_W=32, RD_EXTRA=16, ADDR_W=8, DATA_W=12).
//   - The state enum typedef {IDLE, SETUP, SHIFT, HOLD, GAP}.
// - Sub-module spi_sck_gen: CLK_DIV counter that emits sck_rise/sck_fall one-cycle strobes and the SCK level, with enable and async clear.
// - The main FSM, shift register and bit counter live in spi_reg_master.
// TESTING
// - Write, CLK_DIV=2: addr 8'h05, data 12'hABC -> MOSI bits on SCK rises = 32'hFB050ABC.
//   - Expect CS low for exactly 32 SCK periods and one Rsp_valid pulse with Rsp_rdata=0.
// - Read, addr 8'h12, MISO model replies 16'h05A3 -> command on MOSI = 32'hFD120000, 48 SCK rises, Rsp_rdata=12'h5A3.
// - Back-to-back: Req_valid held high for write then read -> Req_ready low throughout each frame.
//   - Expect CS high for >= GAP_HALVES*CLK_DIV cycles between frames, both frames correct.
// - Reset mid-frame: drop Rst_n after the 10th SCK rise -> CS=1 and SCK=0 in the same timestep, no Rsp_valid.
//   - After release, Req_ready=1 and the next write completes correctly.
// - CLK_DIV=1 boundary: write addr 8'hFF, data 12'hFFF -> SCK period = 2 Clk cycles, frame 32'hFBFF0FFF.
//   - Expect write latency 67 Clk cycles to Rsp_valid.
// - System: connect to filter_top, write 32 coefficients from packets.txt, read each back -> Rsp_rdata equals the written value for every address.

Source files
------------

// File: rtl/spi_reg_pkg.sv
// Shared frame geometry, preamble defaults and FSM state encoding for the SPI register initiator.
// The frame layout is {preamble, addr, 4'b0000, data}; reads append RD_EXTRA reply clocks.
package spi_reg_pkg;

    localparam int FRAME_W  = 32;
    localparam int RD_EXTRA = 16;
    localparam int ADDR_W   = 8;
    localparam int DATA_W   = 12;
    localparam int PRE_W    = 8;
    localparam int PAD_W    = FRAME_W - PRE_W - ADDR_W - DATA_W;

    localparam logic [PRE_W-1:0] WR_PREAMBLE_DEF = 8'hFB;
    localparam logic [PRE_W-1:0] RD_PREAMBLE_DEF = 8'hFD;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } state_t;

    function automatic logic [FRAME_W-1:0] build_frame(
        input logic [PRE_W-1:0]  pre,
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] data
    );
        return {pre, addr, {PAD_W{1'b0}}, data};
    endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// SCK divider: toggles SCK every CLK_DIV cycles while enabled, with same-cycle rise/fall strobes.
// Disabling (or reset) parks SCK low and clears the divider so the next enable starts with a full low half.
module spi_sck_gen #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    output logic o_sck,
    output logic o_rise,
    output logic o_fall
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    logic [7:0] r_cnt;
    logic       r_sck;
    logic       w_tick;

    assign w_tick = i_en && (r_cnt == DIV_LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
            r_sck <= 1'b0;
        end else if (!i_en) begin
            r_cnt <= '0;
            r_sck <= 1'b0;
        end else if (w_tick) begin
            r_cnt <= '0;
            r_sck <= ~r_sck;
        end else begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    assign o_sck  = r_sck;
    assign o_rise = w_tick && !r_sck;
    assign o_fall = w_tick && r_sck;

endmodule

// File: rtl/spi_reg_master.sv
// SPI mode-0 register initiator: Rsp_valid 66*CLK_DIV+1 cycles after a write is accepted, 98*CLK_DIV+1 after a read.
// Req_ready stays low from acceptance until the CS-high gap has elapsed; a held request simply waits.
module spi_reg_master
    import spi_reg_pkg::*;
#(
    parameter int unsigned      CLK_DIV     = 4,
    parameter logic [PRE_W-1:0] WR_PREAMBLE = WR_PREAMBLE_DEF,
    parameter logic [PRE_W-1:0] RD_PREAMBLE = RD_PREAMBLE_DEF,
    parameter int unsigned      GAP_HALVES  = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_rw,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [DATA_W-1:0] i_req_wdata,
    output logic              o_rsp_valid,
    output logic [DATA_W-1:0] o_rsp_rdata,
    output logic              o_busy,
    output logic              o_sck,
    output logic              o_cs,
    output logic              o_mosi,
    input  logic              i_miso
);

    localparam logic [15:0] SETUP_LAST = 16'(CLK_DIV);
    localparam logic [15:0] HOLD_LAST  = 16'(CLK_DIV - 1);
    localparam logic [15:0] GAP_LAST   = 16'(GAP_HALVES * CLK_DIV - 1);
    localparam logic [5:0]  WR_BITS    = 6'(FRAME_W);
    localparam logic [5:0]  RD_BITS    = 6'(FRAME_W + RD_EXTRA);

    state_t              r_state;
    logic [15:0]         r_div;
    logic [FRAME_W-1:0]  r_shift;
    logic [DATA_W-1:0]   r_rx;
    logic [5:0]          r_bits;
    logic                r_rw;
    logic                r_cs;
    logic                r_mosi;
    logic                r_ready;
    logic                r_busy;
    logic                r_rsp_vld;
    logic [DATA_W-1:0]   r_rdata;

    logic                w_accept;
    logic                w_sck_en;
    logic                w_sck;
    logic                w_rise;
    logic                w_fall;
    logic [5:0]          w_len;
    logic [FRAME_W-1:0]  w_frame;

    assign w_accept = i_req_valid && r_ready;
    assign w_sck_en = (r_state == SHIFT);
    assign w_len    = r_rw ? RD_BITS : WR_BITS;
    assign w_frame  = build_frame(i_req_rw ? RD_PREAMBLE : WR_PREAMBLE, i_req_addr,
                                  i_req_rw ? {DATA_W{1'b0}} : i_req_wdata);

    spi_sck_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sck_gen (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (w_sck_en),
        .o_sck   (w_sck),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= IDLE;
            r_div     <= '0;
            r_shift   <= '0;
            r_rx      <= '0;
            r_bits    <= '0;
            r_rw      <= 1'b0;
            r_cs      <= 1'b1;
            r_mosi    <= 1'b0;
            r_ready   <= 1'b1;
            r_busy    <= 1'b0;
            r_rsp_vld <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_rsp_vld <= 1'b0;
            case (r_state)
                IDLE: begin
                    // MSB goes straight onto MOSI; the shifter holds the remaining bits pre-aligned.
                    if (w_accept) begin
                        r_state <= SETUP;
                        r_div   <= '0;
                        r_rw    <= i_req_rw;
                        r_shift <= {w_frame[FRAME_W-2:0], 1'b0};
                        r_mosi  <= w_frame[FRAME_W-1];
                        r_cs    <= 1'b0;
                        r_bits  <= '0;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                SETUP: begin
                    if (r_div == SETUP_LAST) begin
                        r_state <= SHIFT;
                        r_div   <= '0;
                    end else begin
                        r_div <= r_div + 16'd1;
                    end
                end
                SHIFT: begin
                    if (w_rise) begin
                        r_rx <= {r_rx[DATA_W-2:0], i_miso};
                        if (r_bits != w_len) begin
                            r_bits <= r_bits + 6'd1;
                        end
                    end
                    if (w_fall) begin
                        if (r_bits == w_len) begin
                            r_state <= HOLD;
                            r_div   <= '0;
                            r_mosi  <= 1'b0;
                        end else begin
                            r_mosi  <= r_shift[FRAME_W-1];
                            r_shift <= {r_shift[FRAME_W-2:0], 1'b0};
                        end
                    end
                end
                HOLD: begin
                    // r_rx is only DATA_W deep, so the 4 leading reply bits have already fallen off.
                    if (r_div == HOLD_LAST) begin
                        r_state   <= GAP;
                        r_div     <= '0;
                        r_cs      <= 1'b1;
                        r_rsp_vld <= 1'b1;
                        r_rdata   <= r_rw ? r_rx : {DATA_W{1'b0}};
                    end else begin
                        r_div <= r_div + 16'd1;
                    end
                end
                GAP: begin
                    if (r_div == GAP_LAST) begin
                        r_state <= IDLE;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_div <= r_div + 16'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_req_ready = r_ready;
    assign o_rsp_valid = r_rsp_vld;
    assign o_rsp_rdata = r_rdata;
    assign o_busy      = r_busy;
    assign o_sck       = w_sck;
    assign o_cs        = r_cs;
    assign o_mosi      = r_mosi;

endmodule

// File: tb/tb_spi_reg_master.sv
// Bench for spi_reg_master: CLK_DIV=2 instance for table-driven frames and mid-frame reset,
// CLK_DIV=1 instance for the SCK=Clk/2 boundary.
module tb_spi_reg_master;

    localparam int CLKP       = 10;
    localparam int CLK_DIV    = 2;
    localparam int GAP_HALVES = 2;
    localparam int NV         = 7;

    typedef struct {
        logic        rw;
        logic [7:0]  addr;
        logic [11:0] wdata;
        logic [15:0] reply;
        logic [31:0] frame;
        logic [11:0] rdata;
        int          lat;
    } vec_t;

    typedef struct {
        logic        rw;
        logic [31:0] frame;
        logic [11:0] rdata;
        int          lat;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        req_valid = 1'b0;
    logic        req_rw = 1'b0;
    logic [7:0]  req_addr = '0;
    logic [11:0] req_wdata = '0;
    logic        req_ready, rsp_valid, busy, sck, cs, mosi;
    logic [11:0] rsp_rdata;
    logic        miso = 1'b0;

    logic        req1_valid = 1'b0;
    logic        req1_rw = 1'b0;
    logic [7:0]  req1_addr = '0;
    logic [11:0] req1_wdata = '0;
    logic        req1_ready, rsp1_valid, busy1, sck1, cs1, mosi1;
    logic [11:0] rsp1_rdata;
    logic        miso1 = 1'b0;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;

    // Monitor bookkeeping
    int          nrise = 0;
    int          frame_start_rise = 0;
    logic [47:0] cap48 = '0;
    logic        prev_cs = 1'b1;
    logic        rdy_hi = 1'b0;
    int          rise_cyc = 0;
    int          last_gap = 0;
    int          rsp_cnt = 0;
    logic [15:0] cur_reply = '0;

    int          nrise1 = 0;
    logic [31:0] cap1 = '0;
    time         t_r0 = 0;
    time         t_r1 = 0;

    vec_t        vecs[NV];
    exp_t        q[$];

    spi_reg_master #(
        .CLK_DIV     (CLK_DIV),
        .WR_PREAMBLE (8'hFB),
        .RD_PREAMBLE (8'hFD),
        .GAP_HALVES  (GAP_HALVES)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_req_rw    (req_rw),
        .i_req_addr  (req_addr),
        .i_req_wdata (req_wdata),
        .o_rsp_valid (rsp_valid),
        .o_rsp_rdata (rsp_rdata),
        .o_busy      (busy),
        .o_sck       (sck),
        .o_cs        (cs),
        .o_mosi      (mosi),
        .i_miso      (miso)
    );

    spi_reg_master #(
        .CLK_DIV     (1),
        .WR_PREAMBLE (8'hFB),
        .RD_PREAMBLE (8'hFD),
        .GAP_HALVES  (GAP_HALVES)
    ) dut1 (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req_valid (req1_valid),
        .o_req_ready (req1_ready),
        .i_req_rw    (req1_rw),
        .i_req_addr  (req1_addr),
        .i_req_wdata (req1_wdata),
        .o_rsp_valid (rsp1_valid),
        .o_rsp_rdata (rsp1_rdata),
        .o_busy      (busy1),
        .o_sck       (sck1),
        .o_cs        (cs1),
        .o_mosi      (mosi1),
        .i_miso      (miso1)
    );

    always #(CLKP/2) clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge sck) begin
        cap48 = {cap48[46:0], mosi};
        nrise = nrise + 1;
    end

    // Slave model: mode 0, reply bits change on SCK fall, MSB first after the 32-bit command.
    always @(negedge sck) begin
        int n;
        n = nrise - frame_start_rise;
        if (n >= 32 && n < 48) miso = cur_reply[47-n];
        else                   miso = 1'b0;
    end

    always @(posedge sck1) begin
        cap1 = {cap1[30:0], mosi1};
        if (nrise1 == 0)      t_r0 = $time;
        else if (nrise1 == 1) t_r1 = $time;
        nrise1 = nrise1 + 1;
    end

    always @(negedge clk) begin
        if (prev_cs && !cs) begin
            rdy_hi           = 1'b0;
            frame_start_rise = nrise;
            last_gap         = cyc - rise_cyc;
        end
        if (!prev_cs && cs) rise_cyc = cyc;
        if (!cs && req_ready) rdy_hi = 1'b1;
        if (rsp_valid) rsp_cnt = rsp_cnt + 1;
        prev_cs = cs;
    end

    initial begin
        #(CLKP * 40000);
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic apply(input vec_t v);
        req_rw    = v.rw;
        req_addr  = v.addr;
        req_wdata = v.wdata;
    endtask

    task automatic wait_accept(output bit ok);
        int t;
        t = 0;
        while (!req_ready && t < 2000) begin
            @(negedge clk);
            t++;
        end
        ok = (t < 2000);
        if (ok) @(posedge clk);
    endtask

    task automatic push_exp(input vec_t v);
        exp_t e;
        e.rw    = v.rw;
        e.frame = v.frame;
        e.rdata = v.rdata;
        e.lat   = v.lat;
        e.acc   = cyc;
        q.push_back(e);
        cur_reply = v.reply;
    endtask

    task automatic check_rsp(input bit chk_gap);
        int          t;
        int          rises;
        exp_t        e;
        logic [31:0] fr;
        t = 0;
        while (!rsp_valid && t < 5000) begin
            @(negedge clk);
            t++;
        end
        chk("rsp_seen", 32'(t < 5000), 32'd1);
        if (t >= 5000 || q.size() == 0) return;
        e     = q.pop_front();
        rises = nrise - frame_start_rise;
        fr    = e.rw ? cap48[47:16] : cap48[31:0];
        chk("latency",       32'(cyc - e.acc), 32'(e.lat));
        chk("sck_rises",     32'(rises), e.rw ? 32'd48 : 32'd32);
        chk("mosi_frame",    fr, e.frame);
        chk("rsp_rdata",     32'(rsp_rdata), 32'(e.rdata));
        chk("ready_in_frame", 32'(rdy_hi), 32'd0);
        chk("busy_at_rsp",   32'(busy), 32'd1);
        chk("cs_at_rsp",     32'(cs), 32'd1);
        if (chk_gap) chk("cs_gap_min", 32'(last_gap >= GAP_HALVES * CLK_DIV), 32'd1);
        @(negedge clk);
        chk("rsp_one_cycle", 32'(rsp_valid), 32'd0);
        chk("rdata_held",    32'(rsp_rdata), 32'(e.rdata));
    endtask

    initial begin
        bit ok;
        int t;
        int rsp_snap;
        int acc1;
        vec_t post;

        vecs[0] = '{1'b0, 8'h05, 12'hABC, 16'h0000, 32'hFB050ABC, 12'h000, 133};
        vecs[1] = '{1'b1, 8'h12, 12'hFFF, 16'h05A3, 32'hFD120000, 12'h5A3, 197};
        vecs[2] = '{1'b0, 8'h00, 12'h000, 16'hFFFF, 32'hFB000000, 12'h000, 133};
        vecs[3] = '{1'b1, 8'hFF, 12'h777, 16'hFFFF, 32'hFDFF0000, 12'hFFF, 197};
        vecs[4] = '{1'b1, 8'h80, 12'h000, 16'hF000, 32'hFD800000, 12'h000, 197};
        vecs[5] = '{1'b1, 8'h3C, 12'h000, 16'hA55A, 32'hFD3C0000, 12'h55A, 197};
        vecs[6] = '{1'b0, 8'h3C, 12'h123, 16'h0000, 32'hFB3C0123, 12'h000, 133};
        post    = '{1'b0, 8'hA5, 12'h5C3, 16'h0000, 32'hFBA505C3, 12'h000, 133};

        repeat (3) @(negedge clk);
        chk("rst_cs",        32'(cs), 32'd1);
        chk("rst_sck",       32'(sck), 32'd0);
        chk("rst_mosi",      32'(mosi), 32'd0);
        chk("rst_ready",     32'(req_ready), 32'd1);
        chk("rst_busy",      32'(busy), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        chk("rst_cs_div1",   32'(cs1), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // Back-to-back: valid stays high, next request's fields presented right after each acceptance.
        apply(vecs[0]);
        req_valid = 1'b1;
        for (int i = 0; i < NV; i++) begin
            wait_accept(ok);
            chk("accept", 32'(ok), 32'd1);
            if (!ok) break;
            #1;
            push_exp(vecs[i]);
            if (i < NV - 1) apply(vecs[i+1]);
            else            req_valid = 1'b0;
            check_rsp(i > 0);
        end

        // Reset in the middle of a write frame.
        @(negedge clk);
        req_rw    = 1'b0;
        req_addr  = 8'h33;
        req_wdata = 12'h456;
        req_valid = 1'b1;
        wait_accept(ok);
        chk("abort_accept", 32'(ok), 32'd1);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        t = 0;
        while ((nrise - frame_start_rise) < 10 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        chk("abort_reach_10_rises", 32'(t < 1000), 32'd1);
        chk("abort_sck_high_before", 32'(sck), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_cs_async",  32'(cs), 32'd1);
        chk("abort_sck_async", 32'(sck), 32'd0);
        rsp_snap = rsp_cnt;
        repeat (4) @(negedge clk);
        #1;
        chk("abort_no_rsp",   32'(rsp_cnt), 32'(rsp_snap));
        chk("abort_rsp_low",  32'(rsp_valid), 32'd0);
        chk("abort_busy_low", 32'(busy), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("after_rst_ready", 32'(req_ready), 32'd1);
        apply(post);
        req_valid = 1'b1;
        wait_accept(ok);
        chk("post_accept", 32'(ok), 32'd1);
        #1;
        push_exp(post);
        req_valid = 1'b0;
        check_rsp(1'b0);

        // CLK_DIV=1 boundary on the second instance.
        @(negedge clk);
        req1_rw    = 1'b0;
        req1_addr  = 8'hFF;
        req1_wdata = 12'hFFF;
        req1_valid = 1'b1;
        t = 0;
        while (!req1_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        @(posedge clk);
        #1;
        acc1 = cyc;
        req1_valid = 1'b0;
        t = 0;
        while (!rsp1_valid && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("div1_rsp_seen",  32'(t < 500), 32'd1);
        chk("div1_latency",   32'(cyc - acc1), 32'd67);
        chk("div1_frame",     cap1, 32'hFBFF0FFF);
        chk("div1_rises",     32'(nrise1), 32'd32);
        chk("div1_rdata",     32'(rsp1_rdata), 32'd0);
        chk("div1_sck_period", 32'(t_r1 - t_r0), 32'(2 * CLKP));
        @(negedge clk);
        chk("div1_rsp_one_cycle", 32'(rsp1_valid), 32'd0);

        @(negedge clk);
        #1;
        chk("total_rsp_count", 32'(rsp_cnt), 32'(NV + 1));
        chk("scoreboard_empty", 32'(q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
